// File: rtl/rv_pkg.sv
// Shared register-file definitions: default widths and the register-address type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Register file bundle: two read ports, ALU/load write ports, load-issue and scoreboard status.
// Latency: read data and hazard are combinational, pend_cnt is registered.
// Backpressure: none; the pipeline stalls itself on hazard.
interface reg_file_sb_if
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            we_a;
    logic [AW-1:0]   wa_a;
    logic [XLEN-1:0] wd_a;
    logic            we_b;
    logic [AW-1:0]   wa_b;
    logic [XLEN-1:0] wd_b;
    logic            ld_issue;
    logic [AW-1:0]   ld_rd;
    logic            hazard;
    logic [CW-1:0]   pend_cnt;

    // Pipeline side: issues reads, writebacks and loads.
    modport master (
        output rs1_addr, rs2_addr, we_a, wa_a, wd_a, we_b, wa_b, wd_b, ld_issue, ld_rd,
        input  rd1_data, rd2_data, hazard, pend_cnt
    );

    // Register file side.
    modport slave (
        input  rs1_addr, rs2_addr, we_a, wa_a, wd_a, we_b, wa_b, wd_b, ld_issue, ld_rd,
        output rd1_data, rd2_data, hazard, pend_cnt
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Load scoreboard: busy bit per register plus a running count of pending registers.
// Latency: hazard combinational; busy and pend_cnt update on the next rising edge.
// Backpressure: none; loads are always accepted, even while hazard is high.
// Ports: clk, rst (sync, active-high); ld_issue/ld_rd set busy; clr_en/clr_addr clear busy;
//        rs1_addr/rs2_addr probe busy for hazard; pend_cnt = popcount(busy).
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int CW    = $clog2(NREGS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          hazard,
    output logic [CW-1:0] pend_cnt
);
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             set_en;
    logic             clr_nz;
    logic             inc;
    logic             dec;

    // x0 is never tracked: its set and clear requests are dropped here.
    assign set_en = ld_issue && (ld_rd != '0);
    assign clr_nz = clr_en && (clr_addr != '0);

    // Count moves only on a real 0->1 or 1->0 transition. A clear that
    // collides with a set of the same register loses, so it cannot decrement.
    assign inc = set_en && !busy[ld_rd];
    assign dec = clr_nz && busy[clr_addr] && !(set_en && (ld_rd == clr_addr));

    always_comb begin
        busy_nxt = busy;
        if (clr_nz) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[ld_rd]    = 1'b1;
    end

    assign hazard = ((rs1_addr != '0) && busy[rs1_addr]) ||
                    ((rs2_addr != '0) && busy[rs2_addr]) ||
                    (ld_issue && (ld_rd != '0) && busy[ld_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (inc && !dec)      pend_cnt <= pend_cnt + 1'b1;
            else if (dec && !inc) pend_cnt <= pend_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file (x0 hard-wired to zero) with two write ports, optional write-to-read bypass and load scoreboard.
// Latency: reads and hazard combinational; writes visible from storage one cycle later.
// Backpressure: none; hazard is advisory and the pipeline decides when to stall.
// Ports: clk, rst (sync, active-high); bus = reg_file_sb_if.slave (read, write A/B, load issue, status).
module reg_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [XLEN-1:0] regs [NREGS];

    // Port A is written last so it wins when both ports target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (bus.we_b && (bus.wa_b != '0)) regs[bus.wa_b] <= bus.wd_b;
            if (bus.we_a && (bus.wa_a != '0)) regs[bus.wa_a] <= bus.wd_a;
        end
    end

    // Read mux: x0 first, then in-flight writes (A before B) when bypass is on,
    // otherwise the stored value. Bypass deliberately ignores rst.
    function automatic logic [XLEN-1:0] rd_sel(input logic [AW-1:0] addr);
        if (addr == '0)                                   return '0;
        if ((BYPASS != 0) && bus.we_a && (bus.wa_a == addr)) return bus.wd_a;
        if ((BYPASS != 0) && bus.we_b && (bus.wa_b == addr)) return bus.wd_b;
        return regs[addr];
    endfunction

    assign bus.rd1_data = rd_sel(bus.rs1_addr);
    assign bus.rd2_data = rd_sel(bus.rs2_addr);

    // Load writebacks on port B retire the matching scoreboard entry.
    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW),
        .CW    (CW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .ld_issue (bus.ld_issue),
        .ld_rd    (bus.ld_rd),
        .clr_en   (bus.we_b),
        .clr_addr (bus.wa_b),
        .rs1_addr (bus.rs1_addr),
        .rs2_addr (bus.rs2_addr),
        .hazard   (bus.hazard),
        .pend_cnt (bus.pend_cnt)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one BYPASS=1 and one BYPASS=0 instance driven identically.
// Directed vector table first, then random traffic checked against an array-based model.
module tb_reg_file_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        we_a, we_b, ld_issue;
    logic [4:0]  wa_a, wa_b, ld_rd, rs1, rs2;
    logic [31:0] wd_a, wd_b;

    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus1 ();
    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus0 ();

    assign bus1.rs1_addr = rs1, bus1.rs2_addr = rs2, bus1.we_a = we_a, bus1.wa_a = wa_a,
           bus1.wd_a = wd_a, bus1.we_b = we_b, bus1.wa_b = wa_b, bus1.wd_b = wd_b,
           bus1.ld_issue = ld_issue, bus1.ld_rd = ld_rd;
    assign bus0.rs1_addr = rs1, bus0.rs2_addr = rs2, bus0.we_a = we_a, bus0.wa_a = wa_a,
           bus0.wd_a = wd_a, bus0.we_b = we_b, bus0.wa_b = wa_b, bus0.wd_b = wd_b,
           bus0.ld_issue = ld_issue, bus0.ld_rd = ld_rd;

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus1));
    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // ---------------- reference model ----------------
    logic [31:0] mreg  [NREGS];
    bit          mbusy [NREGS];

    function automatic int m_pend();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we_a && wa_a == a) return wd_a;
        if (byp && we_b && wa_b == a) return wd_b;
        return mreg[a];
    endfunction

    function automatic bit m_hz();
        return mbusy[rs1] || mbusy[rs2] || (ld_issue && mbusy[ld_rd]);
    endfunction

    // Applied right after the rising edge, while the inputs it sampled still hold.
    task automatic m_edge();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin mreg[i] = 32'h0; mbusy[i] = 1'b0; end
        end else begin
            if (we_b && wa_b != 5'd0) mreg[wa_b] = wd_b;
            if (we_a && wa_a != 5'd0) mreg[wa_a] = wd_a;   // A wins a collision
            if (we_b && wa_b != 5'd0) mbusy[wa_b] = 1'b0;
            if (ld_issue && ld_rd != 5'd0) mbusy[ld_rd] = 1'b1;   // set wins
        end
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst; logic we_a; logic [4:0] wa_a; logic [31:0] wd_a;
        logic we_b; logic [4:0] wa_b; logic [31:0] wd_b;
        logic ld; logic [4:0] ld_rd; logic [4:0] rs1; logic [4:0] rs2;
        logic [31:0] e_rd1; logic [31:0] e_rd1_nb; logic [31:0] e_rd2;
        logic e_hz; logic [5:0] e_pend;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic wea, input logic [4:0] waa, input logic [31:0] wda,
        input logic web, input logic [4:0] wab, input logic [31:0] wdb,
        input logic ld, input logic [4:0] ldr, input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] e1, input logic [31:0] e1nb, input logic [31:0] e2,
        input logic ehz, input logic [5:0] ep);
        vec_t v;
        v.rst = r; v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
        v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
        v.ld = ld; v.ld_rd = ldr; v.rs1 = a1; v.rs2 = a2;
        v.e_rd1 = e1; v.e_rd1_nb = e1nb; v.e_rd2 = e2; v.e_hz = ehz; v.e_pend = ep;
        return v;
    endfunction

    localparam int NV = 24;
    vec_t tbl [NV];

    initial begin
        // rst we_a wa_a wd_a           we_b wa_b wd_b          ld ld_rd  rs1   rs2    rd1(B=1)      rd1(B=0)      rd2           hz   pend
        tbl[0]  = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd5,  5'd6,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[1]  = mk(0, 1, 5'd10, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 5'd10, 5'd0,  32'hDEADBEEF, 32'h0,        32'h0,        0, 6'd0);
        tbl[2]  = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd10, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 6'd0);
        tbl[3]  = mk(0, 1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, 32'h0,        1, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[4]  = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[5]  = mk(0, 1, 5'd7,  32'h11111111, 1, 5'd7, 32'h22222222, 0, 5'd0, 5'd7,  5'd7,  32'h11111111, 32'h0,        32'h11111111, 0, 6'd0);
        tbl[6]  = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd7,  5'd7,  32'h11111111, 32'h11111111, 32'h11111111, 0, 6'd0);
        tbl[7]  = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd5, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[8]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd5, 32'h55,       1, 5'd5, 5'd5,  5'd0,  32'h55,       32'h0,        32'h0,        1, 6'd1);
        tbl[9]  = mk(0, 0, 5'd0,  32'h0,        1, 5'd5, 32'h55,       0, 5'd0, 5'd5,  5'd0,  32'h55,       32'h55,       32'h0,        1, 6'd1);
        tbl[10] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd5,  5'd0,  32'h55,       32'h55,       32'h0,        0, 6'd0);
        tbl[11] = mk(0, 1, 5'd3,  32'hA5A5A5A5, 0, 5'd0, 32'h0,        1, 5'd3, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[12] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 5'd3,  5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1, 6'd1);
        tbl[13] = mk(1, 1, 5'd3,  32'h12345678, 0, 5'd0, 32'h0,        1, 5'd4, 5'd3,  5'd9,  32'h12345678, 32'hA5A5A5A5, 32'h0,        1, 6'd2);
        tbl[14] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd3,  5'd9,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[15] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd6, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[16] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd6, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1, 6'd1);
        tbl[17] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd1);
        tbl[18] = mk(0, 0, 5'd0,  32'h0,        1, 5'd6, 32'h0,        0, 5'd0, 5'd6,  5'd0,  32'h0,        32'h0,        32'h0,        1, 6'd1);
        tbl[19] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd6,  5'd0,  32'h0,        32'h0,        32'h0,        0, 6'd0);
        tbl[20] = mk(0, 1, 5'd9,  32'hCAFEF00D, 1, 5'd9, 32'h1,        1, 5'd9, 5'd9,  5'd0,  32'hCAFEF00D, 32'h0,        32'h0,        0, 6'd0);
        tbl[21] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd9,  5'd0,  32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        1, 6'd1);
        tbl[22] = mk(0, 0, 5'd0,  32'h0,        1, 5'd9, 32'hBB,       0, 5'd0, 5'd9,  5'd0,  32'hBB,       32'hCAFEF00D, 32'h0,        1, 6'd1);
        tbl[23] = mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd9,  5'd0,  32'hBB,       32'hBB,       32'h0,        0, 6'd0);

        rst = 1'b1; we_a = 1'b0; we_b = 1'b0; ld_issue = 1'b0;
        wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; ld_rd = '0; rs1 = 5'd5; rs2 = 5'd6;
        for (int i = 0; i < NREGS; i++) begin mreg[i] = 32'h0; mbusy[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors; outputs sampled on the falling edge before the write edge.
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; we_a = tbl[i].we_a; wa_a = tbl[i].wa_a; wd_a = tbl[i].wd_a;
            we_b = tbl[i].we_b; wa_b = tbl[i].wa_b; wd_b = tbl[i].wd_b;
            ld_issue = tbl[i].ld; ld_rd = tbl[i].ld_rd; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
            @(negedge clk);
            check($sformatf("vec%0d rd1", i),    64'(bus1.rd1_data), 64'(tbl[i].e_rd1));
            check($sformatf("vec%0d rd1_nb", i), 64'(bus0.rd1_data), 64'(tbl[i].e_rd1_nb));
            check($sformatf("vec%0d rd2", i),    64'(bus1.rd2_data), 64'(tbl[i].e_rd2));
            check($sformatf("vec%0d hazard", i), 64'(bus1.hazard),   64'(tbl[i].e_hz));
            check($sformatf("vec%0d pend", i),   64'(bus1.pend_cnt), 64'(tbl[i].e_pend));
            @(posedge clk);
            m_edge();
            #1;
        end

        // Random traffic, addresses biased to a small window so collisions are common.
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            we_a     = 1'($urandom_range(0, 1));
            we_b     = 1'($urandom_range(0, 2) == 0);
            ld_issue = 1'($urandom_range(0, 2) == 0);
            wa_a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa_b  = 5'($urandom_range(0, 7));
            ld_rd = 5'($urandom_range(0, 7));
            rs1   = 5'($urandom_range(0, 7));
            rs2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd_a  = $urandom;
            wd_b  = $urandom;
            @(negedge clk);
            check($sformatf("rnd%0d rd1", c),    64'(bus1.rd1_data), 64'(m_rd(rs1, 1'b1)));
            check($sformatf("rnd%0d rd2", c),    64'(bus1.rd2_data), 64'(m_rd(rs2, 1'b1)));
            check($sformatf("rnd%0d rd1_nb", c), 64'(bus0.rd1_data), 64'(m_rd(rs1, 1'b0)));
            check($sformatf("rnd%0d rd2_nb", c), 64'(bus0.rd2_data), 64'(m_rd(rs2, 1'b0)));
            check($sformatf("rnd%0d hazard", c), 64'(bus1.hazard),   64'(m_hz()));
            check($sformatf("rnd%0d pend", c),   64'(bus1.pend_cnt), 64'(m_pend()));
            check($sformatf("rnd%0d pend_nb", c),64'(bus0.pend_cnt), 64'(m_pend()));
            @(posedge clk);
            m_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of every register.
REQ-002 Parameter NREGS, default 32, register count (power of two, ≥2); AW = clog2(NREGS) derived.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 rs1_addr, rs2_addr  in  AW  read addresses.
REQ-007 rd1_data, rd2_data  out  XLEN  combinational read data.
REQ-008 we_a, wa_a, wd_a  in  1/AW/XLEN  write port A (ALU writeback).
REQ-009 we_b, wa_b, wd_b  in  1/AW/XLEN  write port B (load writeback); also clears pending bit of wa_b.
REQ-010 ld_issue, ld_rd  in  1/AW  long-latency load issued; marks ld_rd pending.
REQ-011 hazard  out  1  combinational: busy[rs1_addr] | busy[rs2_addr] | (ld_issue & busy[ld_rd]), x0 terms forced 0.
REQ-012 pend_cnt  out  clog2(NREGS+1)  registered number of pending registers.

Function
REQ-013 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded; busy[0] SHALL never be set.
REQ-014 Write: on rising edge, reg[wa_a] <= wd_a when we_a; reg[wa_b] <= wd_b when we_b.
REQ-015 Both ports writing the same nonzero address in one cycle: port A value SHALL be stored.
REQ-016 BYPASS=1: read of address being written this cycle SHALL return the incoming data (port A over port B); BYPASS=0: SHALL return stored value.
REQ-017 Scoreboard busy[NREGS]: set on edge when ld_issue & ld_rd≠0; cleared on edge when we_b & wa_b≠0.
REQ-018 Set and clear of the same register in one cycle: set SHALL win (busy stays 1).
REQ-019 ld_issue while hazard=1 SHALL still be accepted by the scoreboard; stalling is the pipeline's responsibility.
REQ-020 Port A writes SHALL NOT affect busy bits.
REQ-021 pend_cnt SHALL equal popcount(busy) one cycle after each busy update (+1 set-only, −1 clear-only, unchanged both/neither or set of already-busy).
REQ-022 pend_cnt SHALL never exceed NREGS−1 nor underflow; clear of non-busy register leaves count unchanged.
REQ-023 hazard and rd*_data SHALL depend only on current inputs and state (zero-cycle latency); writes visible via storage one cycle later.

Reset
REQ-024 rst=1 at a rising edge SHALL clear all registers to 0, all busy bits to 0, pend_cnt to 0.
REQ-025 Reset SHALL dominate writes, ld_issue and clears in the same cycle.
REQ-026 During rst, rd*_data SHALL read stored (zero) values; bypass stays active per BYPASS.

Structure
REQ-027 Shared package rv_pkg SHALL hold XLEN default, NREGS default, and the register-address typedef.
REQ-028 Scoreboard (busy vector + pend_cnt) SHALL be one sub-module, reg_scoreboard; storage and bypass stay in the top.

Verification
REQ-029 Reset: rst=1 two cycles, then read x5,x6 -> rd1=0x00000000, rd2=0x00000000, pend_cnt=0, hazard=0.
REQ-030 Write/read: we_a, wa_a=10, wd_a=0xDEADBEEF; same-cycle rs1=10 -> 0xDEADBEEF (BYPASS=1), stored value (BYPASS=0); next cycle 0xDEADBEEF both.
REQ-031 x0: we_a wa_a=0 wd_a=0xFFFFFFFF; ld_issue ld_rd=0 -> rs1=0 reads 0, pend_cnt=0, hazard=0.
REQ-032 Conflict: we_a wa_a=7 wd_a=0x11111111 and we_b wa_b=7 wd_b=0x22222222 -> reg7=0x11111111.
REQ-033 Scoreboard: ld_issue rd=5 -> pend_cnt=1, rs1=5 hazard=1; we_b wa_b=5 wd_b=0x55 with ld_issue rd=5 same cycle -> busy[5]=1, pend_cnt=1; we_b wa_b=5 alone -> pend_cnt=0, hazard=0, reg5=0x55.
REQ-034 Reset mid-operation: busy[3],busy[9] set, reg3=0xA5A5A5A5, assert rst with we_a wa_a=3 -> reg3=0, pend_cnt=0, hazard=0.
